// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding and the
// address-alignment helper used by the fetch stage.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } fetch_state_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSTR_BYTES - 1));
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: one outstanding word read at a time, redirect handling
// with wrong-path response discard, and a valid/ready port to the decoder.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] instr_q_reg, instr_q_next;
    logic [XLEN-1:0] pc_q_reg, pc_q_next;
    logic            drop_reg, drop_next;

    logic            req_fire;
    logic            resp_fire;
    logic            discard_resp;
    logic [XLEN-1:0] redirect_target;

    assign req_fire        = (state_reg == REQ) && mem_req_ready;
    assign resp_fire       = (state_reg == WAIT) && mem_resp_valid;
    // A response is thrown away if it belongs to an older path or a redirect lands with it.
    assign discard_resp    = drop_reg || redirect_valid;
    assign redirect_target = word_align(redirect_pc);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            instr_q_reg <= '0;
            pc_q_reg    <= '0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_q_reg <= instr_q_next;
            pc_q_reg    <= pc_q_next;
            drop_reg    <= drop_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (req_fire) state_next = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) state_next = discard_resp ? REQ : FULL;
            end
            FULL: begin
                // With no redirect instr_valid is high, so instr_ready alone completes the transfer.
                if (redirect_valid || instr_ready) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        pc_next      = pc_reg;
        pc_q_next    = pc_q_reg;
        instr_q_next = instr_q_reg;
        drop_next    = drop_reg;

        if (req_fire) begin
            pc_q_next = pc_reg;
            pc_next   = pc_reg + XLEN'(INSTR_BYTES);
        end

        if (resp_fire) begin
            if (discard_resp) drop_next = 1'b0;
            else              instr_q_next = mem_resp_data;
        end

        if (redirect_valid) begin
            pc_next = redirect_target;
            // A read is (or is about to be) in flight on the old path and must be ignored.
            if (req_fire || ((state_reg == WAIT) && !mem_resp_valid)) drop_next = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        mem_req_valid = (state_reg == REQ);
        mem_req_addr  = pc_reg;
        instr_valid   = (state_reg == FULL) && !redirect_valid;
        instruction   = instr_q_reg;
        instr_pc      = pc_q_reg;
    end

    // Memory must only answer while a request is outstanding.
    resp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n) mem_resp_valid |-> (state_reg == WAIT)
    );

    // Single outstanding request: no new request may be presented while waiting.
    no_req_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) (state_reg == WAIT) |-> !mem_req_valid
    );

endmodule
